// File: rtl/buffer_write_arbiter.sv
// Round-robin arbiter sharing the single Buffer write port between NUM_CH sample producers.
// Four-phase req/ack toward the producers, valid/ack toward Buffer, watchdog drop on a missing ack.
module buffer_write_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 9,
  parameter int TIMEOUT = 64,
  localparam int GW     = $clog2(NUM_CH),
  localparam int WW     = $clog2(TIMEOUT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] req_data,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ack,
  output logic [DATA_W-1:0]        buf_data_in,
  output logic                     buf_data_valid,
  input  logic                     buf_data_ack,
  output logic [GW-1:0]            grant_id,
  output logic                     busy,
  output logic                     drop_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [GW-1:0]       last_grant_r, last_grant_s;
  logic [WW-1:0]       wdog_r, wdog_s;
  logic [GW-1:0]       pick_s;
  logic                found_s;
  logic [GW:0]         cand_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic [DATA_W-1:0]   data_s;
  logic                valid_s;
  logic [NUM_CH-1:0]   ack_s;
  logic [GW-1:0]       grant_s;
  logic                drop_s;

  function automatic logic [NUM_CH-1:0] onehot(input logic [GW-1:0] idx);
    onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign busy = (state_r != ST_IDLE);

  // Round-robin pick: first requester scanning upward from last_grant+1, wrapping mod NUM_CH
  always_comb begin
    pick_s  = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand_s = {1'b0, last_grant_r} + (GW+1)'(i);
      if (cand_s >= (GW+1)'(NUM_CH)) begin
        cand_s = cand_s - (GW+1)'(NUM_CH);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req_valid[cand_s[GW-1:0]]) begin
        found_s = 1'b1;
        pick_s  = cand_s[GW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Sample mux for the picked channel
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pick_s == GW'(i)) begin
        sel_data_s = req_data[i*DATA_W +: DATA_W];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    wdog_s       = wdog_r;
    data_s       = buf_data_in;
    valid_s      = buf_data_valid;
    ack_s        = req_ack;
    grant_s      = grant_id;
    drop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          data_s  = sel_data_s;
          grant_s = pick_s;
          valid_s = 1'b1;
          wdog_s  = '0;
          state_s = ST_WRITE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        // A late retraction of req_valid is ignored so Buffer never sees a pulled sample
        if (buf_data_ack) begin
          valid_s      = 1'b0;
          ack_s        = onehot(grant_id);
          last_grant_s = grant_id;
          state_s      = ST_RELEASE;
        end else if (wdog_r == WW'(TIMEOUT-1)) begin
          valid_s      = 1'b0;
          ack_s        = onehot(grant_id);
          last_grant_s = grant_id;
          drop_s       = 1'b1;
          state_s      = ST_RELEASE;
        end else begin
          wdog_s = wdog_r + WW'(1);
        end
      end
      ST_RELEASE: begin
        if (!req_valid[grant_id]) begin
          ack_s   = '0;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RELEASE;
        end
      end
      default: begin
        valid_s = 1'b0;
        ack_s   = '0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, watchdog and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      last_grant_r   <= GW'(NUM_CH-1);
      wdog_r         <= '0;
      buf_data_in    <= '0;
      buf_data_valid <= 1'b0;
      req_ack        <= '0;
      grant_id       <= '0;
      drop_err       <= 1'b0;
    end else begin
      state_r        <= state_s;
      last_grant_r   <= last_grant_s;
      wdog_r         <= wdog_s;
      buf_data_in    <= data_s;
      buf_data_valid <= valid_s;
      req_ack        <= ack_s;
      grant_id       <= grant_s;
      drop_err       <= drop_s;
    end
  end

endmodule

// File: tb/tb_buffer_write_arbiter.sv
// Directed and randomized bench for buffer_write_arbiter (NUM_CH=4, DATA_W=9, TIMEOUT=8).
// Random phase is checked cycle by cycle against a transaction-level reference model.
module tb_buffer_write_arbiter;

  localparam int NC = 4;
  localparam int DW = 9;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NC*DW-1:0] req_data;
  logic [NC-1:0]   req_valid;
  logic [NC-1:0]   req_ack;
  logic [DW-1:0]   buf_data_in;
  logic            buf_data_valid;
  logic            buf_data_ack;
  logic [1:0]      grant_id;
  logic            busy;
  logic            drop_err;

  logic [DW-1:0]   din [NC];
  int errors = 0;
  int checks = 0;

  // reference model state
  int            m_phase, m_last, m_cyc, n, hi, drops;
  logic [1:0]    m_gid, m_idx;
  logic [DW-1:0] m_data;
  logic          m_drop, m_found;

  buffer_write_arbiter #(.NUM_CH(NC), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid), .req_ack(req_ack),
    .buf_data_in(buf_data_in), .buf_data_valid(buf_data_valid), .buf_data_ack(buf_data_ack),
    .grant_id(grant_id), .busy(busy), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NC; i++) req_data[i*DW +: DW] = din[i];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [3:0] a, input logic [1:0] g,
                           input logic b, input logic d, input logic [8:0] dat);
    check({tag, ".valid"}, buf_data_valid, v);
    check({tag, ".ack"}, req_ack, a);
    check({tag, ".gid"}, grant_id, g);
    check({tag, ".busy"}, busy, b);
    check({tag, ".drop"}, drop_err, d);
    check({tag, ".data"}, buf_data_in, dat);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = 4'b0000;
    buf_data_ack = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NC; i++) din[i] = 9'h000;
    // 1: reset with requests active
    rst = 1'b0;
    buf_data_ack = 1'b0;
    req_valid = 4'b1111;
    din[0] = 9'h0A5;
    repeat (3) step();
    check_all("reset", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 9'h000);
    req_valid = 4'b0001;
    rst = 1'b1;
    step();
    check_all("first_grant", 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 9'h0A5);
    buf_data_ack = 1'b1;
    step();
    buf_data_ack = 1'b0;
    check_all("first_ack", 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 9'h0A5);
    step();
    check("first_ack_hold", req_ack, 4'b0001);
    req_valid = 4'b0000;
    step();
    check_all("first_release", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 9'h0A5);

    // 2: single write on ch2, Buffer acks in the third valid cycle
    din[2] = 9'h1FF;
    req_valid = 4'b0100;
    step();
    check_all("ch2_c1", 1'b1, 4'b0000, 2'd2, 1'b1, 1'b0, 9'h1FF);
    step();
    check("ch2_c2.valid", buf_data_valid, 1'b1);
    step();
    check("ch2_c3.valid", buf_data_valid, 1'b1);
    buf_data_ack = 1'b1;
    step();
    buf_data_ack = 1'b0;
    check_all("ch2_done", 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 9'h1FF);
    step();
    check("ch2_ack_hold", req_ack, 4'b0100);
    req_valid = 4'b0000;
    step();
    check("ch2_ack_clear", req_ack, 4'b0000);

    // 3: round robin with all channels requesting and Buffer acking at once
    do_reset();
    for (int i = 0; i < NC; i++) din[i] = 9'h100 + 9'(i);
    req_valid = 4'b1111;
    buf_data_ack = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 60 && n < 5; cyc++) begin
      step();
      if (buf_data_valid) begin
        check("rr_gid", grant_id, 32'(n % NC));
        check("rr_data", buf_data_in, 32'h100 + 32'(n % NC));
        n++;
      end
      for (int c = 0; c < NC; c++) begin
        if (req_ack[c]) req_valid[c] = 1'b0;
        else if (!req_valid[c]) req_valid[c] = 1'b1;
      end
    end
    check("rr_count", n, 5);

    // 4: timeout on ch0, then ch1 served
    do_reset();
    din[0] = 9'h055;
    din[1] = 9'h0AA;
    req_valid = 4'b0011;
    step();
    check_all("to_start", 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 9'h055);
    hi = 1;
    drops = 0;
    for (int k = 0; k < 20 && buf_data_valid; k++) begin
      step();
      drops += int'(drop_err);
      if (buf_data_valid) hi++;
    end
    check("to_valid_cycles", hi, TO);
    check("to_drop_now", drop_err, 1'b1);
    check("to_ack", req_ack, 4'b0001);
    step();
    check("to_drop_pulse", drop_err, 1'b0);
    check("to_drops", drops + int'(drop_err), 1);
    req_valid[0] = 1'b0;
    step();
    check("to_release", req_ack, 4'b0000);
    step();
    check_all("to_next", 1'b1, 4'b0000, 2'd1, 1'b1, 1'b0, 9'h0AA);

    // 5: ack arrives on the very cycle the watchdog expires
    repeat (TO-1) step();
    check("race_valid", buf_data_valid, 1'b1);
    buf_data_ack = 1'b1;
    step();
    buf_data_ack = 1'b0;
    check_all("race_done", 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 9'h0AA);
    req_valid = 4'b0000;
    step();
    check("race_idle", busy, 1'b0);

    // 6: async reset in WRITE, then ch0 has priority
    din[2] = 9'h123;
    din[0] = 9'h0F0;
    req_valid = 4'b0100;
    step();
    check("ar_write.gid", grant_id, 2'd2);
    #2 rst = 1'b0;
    #1;
    check_all("ar_async", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 9'h000);
    req_valid = 4'b0101;
    #2 rst = 1'b1;
    step();
    check_all("ar_prio", 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 9'h0F0);

    // randomized producers and Buffer against the reference model
    do_reset();
    m_phase = 0; m_last = NC-1; m_gid = 2'd0; m_data = '0; m_cyc = 0; m_drop = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int c = 0; c < NC; c++) begin
        if (req_valid[c]) begin
          if (req_ack[c] && $urandom_range(1, 0) == 0) req_valid[c] = 1'b0;
        end else if (!req_ack[c] && $urandom_range(3, 0) == 0) begin
          req_valid[c] = 1'b1;
          din[c] = 9'($urandom);
        end
      end
      buf_data_ack = ($urandom_range(3, 0) == 0);
      m_drop = 1'b0;
      if (m_phase == 0) begin
        m_found = 1'b0;
        for (int k = 1; k <= NC; k++) begin
          m_idx = 2'((m_last + k) % NC);
          if (!m_found && req_valid[m_idx]) begin
            m_found = 1'b1;
            m_gid = m_idx;
          end
        end
        if (m_found) begin
          m_phase = 1;
          m_data = din[m_gid];
          m_cyc = 1;
        end
      end else if (m_phase == 1) begin
        if (buf_data_ack || m_cyc == TO) begin
          m_drop = !buf_data_ack;
          m_phase = 2;
          m_last = int'(m_gid);
        end else m_cyc++;
      end else if (!req_valid[m_gid]) m_phase = 0;
      step();
      check_all("rand", m_phase == 1, (m_phase == 2) ? (4'b0001 << m_gid) : 4'b0000,
                m_gid, m_phase != 0, m_drop, m_data);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
